// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR request front end:
// FSM encoding, counter widths and channel indices.
package sr_ctrl_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DB_CNT_W   = 8;
  localparam int HOLD_CNT_W = 4;

  localparam int CH_SET = 1;
  localparam int CH_CLR = 0;
endpackage

// File: rtl/sr_debounce.sv
// One request channel: two-flop synchroniser, debounce counter and debounced
// level, with a combinational rise flag marking the edge on which the level goes 0->1.
module sr_debounce
  import sr_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic                sync1;
  logic                sync2;
  logic [DB_CNT_W-1:0] cnt;
  logic                flip;

  // flip is true on the sampling edge that completes DB_CYCLES differing samples
  assign flip = (sync2 != level) && (cnt == CNT_LAST);
  assign rise = flip && !level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_pulse_gen.sv
// Turns raw set/clear request levels into clean, mutually exclusive one-cycle
// S/R pulses separated by at least HOLDOFF idle cycles.
module sr_pulse_gen
  import sr_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int HOLDOFF   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_raw,
  input  logic       clr_raw,
  input  logic       enable,
  input  logic       ovr_clr,
  output logic       S,
  output logic       R,
  output logic       busy,
  output logic [1:0] ovr
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLDOFF);

  state_t                state;
  logic [HOLD_CNT_W-1:0] hcnt;
  logic [1:0]            level;
  logic [1:0]            rise;
  logic [1:0]            pend;
  logic [1:0]            take;
  logic                  idle_go;

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_set (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (set_raw),
    .level (level[CH_SET]),
    .rise  (rise[CH_SET])
  );

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (clr_raw),
    .level (level[CH_CLR]),
    .rise  (rise[CH_CLR])
  );

  // set wins over clear, mirroring the downstream flip-flop's set priority
  assign idle_go       = (state == IDLE) && enable;
  assign take[CH_SET]  = idle_go && pend[CH_SET];
  assign take[CH_CLR]  = idle_go && !pend[CH_SET] && pend[CH_CLR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hcnt  <= '0;
      S     <= 1'b0;
      R     <= 1'b0;
      busy  <= 1'b0;
      pend  <= '0;
      ovr   <= '0;
    end else begin
      busy <= (state == HOLD) || (|pend);
      // a rise arriving as its pend is consumed re-arms it without an overrun
      pend <= rise | (pend & ~take);
      ovr  <= (ovr & ~{2{ovr_clr}}) | (rise & pend & ~take);
      case (state)
        IDLE: begin
          S <= take[CH_SET];
          R <= take[CH_CLR];
          if (|take) begin
            state <= HOLD;
            hcnt  <= HOLD_LOAD;
          end
        end
        HOLD: begin
          S    <= 1'b0;
          R    <= 1'b0;
          hcnt <= hcnt - 1'b1;
          if (hcnt == HOLD_CNT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(S && R));
  a_rise_from_low: assert property (@(posedge clk) disable iff (!rst_n) (|(rise & level)) == 1'b0);

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Directed checks of sr_pulse_gen timing, glitch rejection, priority, overrun and
// reset abort, followed by a long bounce run against a cycle model.
module tb_sr_pulse_gen;
  localparam int DB_CYCLES = 4;
  localparam int HOLDOFF   = 2;

  logic       clk;
  logic       rst_n;
  logic       set_raw;
  logic       clr_raw;
  logic       enable;
  logic       ovr_clr;
  logic       S;
  logic       R;
  logic       busy;
  logic [1:0] ovr;

  int total = 0;
  int bad   = 0;

  sr_pulse_gen #(.DB_CYCLES(DB_CYCLES), .HOLDOFF(HOLDOFF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_raw (set_raw),
    .clr_raw (clr_raw),
    .enable  (enable),
    .ovr_clr (ovr_clr),
    .S       (S),
    .R       (R),
    .busy    (busy),
    .ovr     (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // pulse monitor, spacing and overlap bookkeeping
  int cyc = 0;
  int s_count = 0;
  int r_count = 0;
  int overlap = 0;
  int spacing_bad = 0;
  int last_pulse = 0;
  bit have_last = 0;
  bit model_on = 0;
  int mism = 0;

  // reference model state
  logic [1:0] ms1 = '0, ms2 = '0, mlev = '0, mpend = '0, rz, tk, rawv;
  int   mcnt [2] = '{0, 0};
  logic mst = 1'b0;
  int   mh = 0;
  logic mS = 1'b0, mR = 1'b0;
  int   rises = 0, merges = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (model_on) begin
      rawv = {set_raw, clr_raw};
      for (int ch = 0; ch < 2; ch++) begin
        rz[ch] = (ms2[ch] != mlev[ch]) && (mcnt[ch] == DB_CYCLES - 1) && !mlev[ch];
        if (ms2[ch] == mlev[ch]) mcnt[ch] = 0;
        else if (mcnt[ch] == DB_CYCLES - 1) begin
          mlev[ch] = ~mlev[ch];
          mcnt[ch] = 0;
        end else mcnt[ch] = mcnt[ch] + 1;
        ms2[ch] = ms1[ch];
        ms1[ch] = rawv[ch];
      end
      tk[1] = !mst && enable && mpend[1];
      tk[0] = !mst && enable && !mpend[1] && mpend[0];
      mS = tk[1];
      mR = tk[0];
      if (mst) begin
        mh = mh - 1;
        if (mh == 0) mst = 1'b0;
      end else if (tk != 2'b00) begin
        mst = 1'b1;
        mh  = HOLDOFF;
      end
      for (int ch = 0; ch < 2; ch++) begin
        if (rz[ch]) rises++;
        if (rz[ch] && mpend[ch] && !tk[ch]) merges++;
        if (rz[ch]) mpend[ch] = 1'b1;
        else if (tk[ch]) mpend[ch] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      have_last = 0;
    end else begin
      if (S && R) overlap++;
      if (S || R) begin
        if (have_last && (cyc - last_pulse) < HOLDOFF + 1) spacing_bad++;
        last_pulse = cyc;
        have_last  = 1;
      end
      if (S) s_count++;
      if (R) r_count++;
      if (model_on && (S !== mS || R !== mR)) mism++;
    end
  end

  int s0, r0, p0;

  initial begin
    rst_n = 1'b0; set_raw = 1'b0; clr_raw = 1'b0; enable = 1'b1; ovr_clr = 1'b0;
    #23;
    check("rst_S", int'(S), 0);
    check("rst_R", int'(R), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovr", int'(ovr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(3);

    // clean set: first captured at edge k, S in the cycle after k+6
    s0 = s_count; r0 = r_count;
    set_raw = 1'b1;
    ticks(6);
    check("set_S_early", int'(S), 0);
    check("set_busy_early", int'(busy), 0);
    tick();
    check("set_S_pulse", int'(S), 1);
    check("set_R_quiet", int'(R), 0);
    check("set_busy_on", int'(busy), 1);
    tick();
    check("set_S_one_cycle", int'(S), 0);
    tick();
    check("set_busy_k8", int'(busy), 1);
    tick();
    check("set_busy_k9", int'(busy), 0);
    set_raw = 1'b0;
    ticks(12);
    check("set_S_count", s_count - s0, 1);
    check("set_R_count", r_count - r0, 0);

    // glitch one sample short of DB_CYCLES is rejected
    r0 = r_count;
    clr_raw = 1'b1;
    ticks(DB_CYCLES - 1);
    clr_raw = 1'b0;
    ticks(15);
    check("glitch_R_count", r_count - r0, 0);
    check("glitch_busy", int'(busy), 0);
    check("glitch_ovr", int'(ovr), 0);
    // exactly DB_CYCLES samples is accepted
    clr_raw = 1'b1;
    ticks(DB_CYCLES);
    clr_raw = 1'b0;
    ticks(15);
    check("min_width_R_count", r_count - r0, 1);

    // simultaneous requests: S at c, R at c+3
    set_raw = 1'b1; clr_raw = 1'b1;
    ticks(7);
    check("sim_S_first", int'(S), 1);
    check("sim_R_wait", int'(R), 0);
    tick();
    check("sim_gap1", int'({S, R}), 0);
    tick();
    check("sim_gap2", int'({S, R}), 0);
    tick();
    check("sim_R_second", int'({S, R}), 1);
    set_raw = 1'b0; clr_raw = 1'b0;
    ticks(15);

    // overrun while disabled, ovr_clr, then re-overrun and release
    s0 = s_count;
    enable = 1'b0;
    set_raw = 1'b1; ticks(8);
    set_raw = 1'b0; ticks(8);
    set_raw = 1'b1; ticks(8);
    set_raw = 1'b0; ticks(8);
    check("ovr_no_S", s_count - s0, 0);
    check("ovr_set_bit", int'(ovr), 2);
    check("ovr_busy", int'(busy), 1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("ovr_cleared", int'(ovr), 0);
    set_raw = 1'b1; ticks(8);
    check("ovr_again", int'(ovr), 2);
    enable = 1'b1;
    tick();
    check("en_S_pulse", int'(S), 1);
    tick();
    check("en_S_hold", int'(S), 0);

    // async reset in HOLD with set_raw still high
    rst_n = 1'b0;
    #3;
    check("arst_S", int'(S), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_ovr", int'(ovr), 0);
    #2;
    rst_n = 1'b1;
    s0 = s_count;
    ticks(DB_CYCLES + 2);
    check("arst_S_early", int'(S), 0);
    tick();
    check("arst_S_pulse", int'(S), 1);
    ticks(10);
    check("arst_S_count", s_count - s0, 1);
    set_raw = 1'b0;
    ticks(20);

    // long random bounce against the cycle model
    p0 = s_count + r_count;
    model_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 9) < 2) set_raw = ~set_raw;
      if ($urandom_range(0, 9) < 2) clr_raw = ~clr_raw;
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      tick();
    end
    set_raw = 1'b0; clr_raw = 1'b0; enable = 1'b1;
    ticks(40);
    check("rnd_model_mism", mism, 0);
    check("rnd_pulse_count", (s_count + r_count) - p0, rises - merges);
    check("rnd_had_edges", int'(rises > 20), 1);
    check("all_overlap", overlap, 0);
    check("all_spacing", spacing_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
